// File: rtl/usb_audio_i2s_tx_pkg.sv
`default_nettype none
// ============================================================================
// Package : usb_audio_pkg
// Shared constants, sample type and PCM conversion helpers for the I2S TX.
// Revision: 1.0 - initial release
// ============================================================================
package usb_audio_pkg;

  localparam int SAMPLE_W   = 16;
  localparam int SLOT_W     = 32;
  localparam int FRAME_BITS = 64;
  localparam int CLK_HZ     = 60_000_000;
  localparam int FS_HZ      = 48_000;
  localparam int FRAME_CLK  = CLK_HZ / FS_HZ;

  localparam int unsigned BCLK_INC_DEF = 1717987;
  localparam int unsigned MCLK_INC_DEF = 6871948;

  // Serialiser bit-position encoding; reset sits one step before the capture slot
  localparam int                CNT_W        = 6;
  localparam logic [CNT_W-1:0]  BIT_CNT_RST  = 6'd62;
  localparam logic [CNT_W-1:0]  BIT_CNT_LAST = 6'd63;

  typedef struct packed {
    logic [SAMPLE_W-1:0] l;
    logic [SAMPLE_W-1:0] r;
  } stereo_sample_t;

  function automatic logic [SAMPLE_W-1:0] ob_to_tc(input logic [SAMPLE_W-1:0] s);
    return s ^ {1'b1, {(SAMPLE_W-1){1'b0}}};
  endfunction

  function automatic logic [FRAME_BITS-1:0] frame_word(input stereo_sample_t s);
    return {ob_to_tc(s.l), {(SLOT_W-SAMPLE_W){1'b0}},
            ob_to_tc(s.r), {(SLOT_W-SAMPLE_W){1'b0}}};
  endfunction

endpackage
`default_nettype wire

// File: rtl/usb_audio_i2s_tx_if.sv
`default_nettype none
// ============================================================================
// Interface : usb_audio_i2s_tx_if
// I2S bus towards the external DAC (MCLK, BCLK, LRCK, SDATA).
// Revision: 1.0 - initial release
// ============================================================================
interface usb_audio_i2s_tx_if;
  logic i2s_mclk;
  logic i2s_bclk;
  logic i2s_lrck;
  logic i2s_sdata;

  modport master (output i2s_mclk, output i2s_bclk, output i2s_lrck, output i2s_sdata);
  modport slave  (input  i2s_mclk, input  i2s_bclk, input  i2s_lrck, input  i2s_sdata);
endinterface
`default_nettype wire

// File: rtl/usb_audio_i2s_tx_nco.sv
`default_nettype none
// ============================================================================
// Module : usb_audio_nco
// Phase accumulator; tick is the carry out of the ACC_W-bit sum.
// Revision: 1.0 - initial release
// ============================================================================
module usb_audio_nco #(
  parameter int ACC_W = 24
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [ACC_W-1:0] inc,
  output logic             tick
);

  logic [ACC_W-1:0] r_acc;
  logic [ACC_W:0]   w_sum;

  assign w_sum = {1'b0, r_acc} + {1'b0, inc};
  assign tick  = w_sum[ACC_W];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_acc <= '0;
    end else begin
      r_acc <= w_sum[ACC_W-1:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/usb_audio_i2s_tx.sv
`default_nettype none
// ============================================================================
// Module : usb_audio_i2s_tx
// I2S master transmitter: 64 BCLK/frame, 32-bit slots, offset-binary in.
// Optional MCLK (256fs) output enabled by defining I2S_MCLK_EN.
// Revision: 1.0 - initial release
// ============================================================================
module usb_audio_i2s_tx
  import usb_audio_pkg::*;
#(
  parameter int               ACC_W    = 24,
  parameter logic [ACC_W-1:0] BCLK_INC = ACC_W'(BCLK_INC_DEF),
  parameter logic [ACC_W-1:0] MCLK_INC = ACC_W'(MCLK_INC_DEF)
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [SAMPLE_W-1:0] audio_L_ch,
  input  logic [SAMPLE_W-1:0] audio_R_ch,
  usb_audio_i2s_tx_if.master  i2s,
  output logic                frame_start
);

  logic                  w_bclk_tick;
  logic                  w_fall;
  stereo_sample_t        w_sample;
  logic [CNT_W-1:0]      w_n;
  logic [CNT_W-1:0]      w_n_inc;

  logic                  r_bclk,        w_bclk_nxt;
  logic [CNT_W-1:0]      r_bit_cnt,     w_bit_cnt_nxt;
  logic [FRAME_BITS-1:0] r_shift,       w_shift_nxt;
  logic                  r_lrck,        w_lrck_nxt;
  logic                  r_sdata,       w_sdata_nxt;
  logic                  r_frame_start, w_frame_start_nxt;

  usb_audio_nco #(.ACC_W(ACC_W)) u_bclk_nco (
    .clk  (clk),
    .rstn (rstn),
    .inc  (BCLK_INC),
    .tick (w_bclk_tick)
  );

  assign w_sample = {audio_L_ch, audio_R_ch};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_bclk        <= 1'b0;
      r_bit_cnt     <= BIT_CNT_RST;
      r_shift       <= '0;
      r_lrck        <= 1'b0;
      r_sdata       <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_bclk        <= w_bclk_nxt;
      r_bit_cnt     <= w_bit_cnt_nxt;
      r_shift       <= w_shift_nxt;
      r_lrck        <= w_lrck_nxt;
      r_sdata       <= w_sdata_nxt;
      r_frame_start <= w_frame_start_nxt;
    end
  end

  always_comb begin
    w_fall            = w_bclk_tick & r_bclk;
    w_n               = (r_bit_cnt == BIT_CNT_LAST) ? '0 : r_bit_cnt + CNT_W'(1);
    w_n_inc           = w_n + CNT_W'(1);
    w_bclk_nxt        = r_bclk;
    w_bit_cnt_nxt     = r_bit_cnt;
    w_shift_nxt       = r_shift;
    w_lrck_nxt        = r_lrck;
    w_sdata_nxt       = r_sdata;
    w_frame_start_nxt = 1'b0;

    if (w_bclk_tick) begin
      w_bclk_nxt = ~r_bclk;
    end

    // Everything data-related moves on the BCLK falling edge; LRCK leads the slot by one bit
    if (w_fall) begin
      w_bit_cnt_nxt = w_n;
      w_lrck_nxt    = w_n_inc[CNT_W-1];
      w_sdata_nxt   = r_shift[FRAME_BITS-1];
      w_shift_nxt   = r_shift << 1;
      if (w_n == BIT_CNT_LAST) begin
        w_shift_nxt       = frame_word(w_sample);
        w_frame_start_nxt = 1'b1;
      end
    end
  end

  always_comb begin
    i2s.i2s_bclk  = r_bclk;
    i2s.i2s_lrck  = r_lrck;
    i2s.i2s_sdata = r_sdata;
    frame_start   = r_frame_start;
  end

`ifdef I2S_MCLK_EN
  logic w_mclk_tick;
  logic r_mclk;

  usb_audio_nco #(.ACC_W(ACC_W)) u_mclk_nco (
    .clk  (clk),
    .rstn (rstn),
    .inc  (MCLK_INC),
    .tick (w_mclk_tick)
  );

  // Free-running: deliberately not aligned to BCLK edges
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_mclk <= 1'b0;
    end else if (w_mclk_tick) begin
      r_mclk <= ~r_mclk;
    end
  end

  assign i2s.i2s_mclk = r_mclk;
`else
  logic w_mclk_inc_unused;
  assign w_mclk_inc_unused = ^MCLK_INC;
  assign i2s.i2s_mclk      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_usb_audio_i2s_tx.sv
`default_nettype none
// ============================================================================
// Testbench : tb_usb_audio_i2s_tx
// Directed checks of reset, slot data, hold, frame timing and mid-frame reset.
// Revision: 1.0 - initial release
// ============================================================================
module tb_usb_audio_i2s_tx;

  logic        clk = 1'b0;
  logic        rstn;
  logic [15:0] audio_L;
  logic [15:0] audio_R;
  logic        frame_start;

  int checks = 0;
  int errors = 0;

  usb_audio_i2s_tx_if i2s_if ();

  usb_audio_i2s_tx dut (
    .clk         (clk),
    .rstn        (rstn),
    .audio_L_ch  (audio_L),
    .audio_R_ch  (audio_R),
    .i2s         (i2s_if),
    .frame_start (frame_start)
  );

  always #8 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_rise(output bit ok);
    logic prev;
    ok   = 1'b0;
    prev = i2s_if.i2s_bclk;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (prev === 1'b0 && i2s_if.i2s_bclk === 1'b1) begin
        ok = 1'b1;
        break;
      end
      prev = i2s_if.i2s_bclk;
    end
  endtask

  task automatic wait_fs(input int limit, output bit ok, output int cyc);
    ok  = 1'b0;
    cyc = 0;
    while (cyc < limit && !ok) begin
      @(negedge clk);
      cyc++;
      if (frame_start === 1'b1) ok = 1'b1;
    end
  endtask

  // Receives one frame as a DAC would: bits sampled on BCLK rising edges after capture
  task automatic rx_frame(input int chg_at, input logic [15:0] new_l,
                          output logic [63:0] data, output logic [63:0] lr,
                          output logic pre, output int fs_wait);
    bit ok;
    bit okr;
    bit all_ok;
    all_ok = 1'b1;
    data   = '0;
    lr     = '0;
    wait_fs(1300, ok, fs_wait);
    check("frame_start_seen", {63'd0, ok}, 64'd1);
    wait_rise(okr);
    all_ok &= okr;
    pre = i2s_if.i2s_sdata;
    for (int i = 0; i < 64; i++) begin
      wait_rise(okr);
      all_ok    &= okr;
      data[63-i] = i2s_if.i2s_sdata;
      lr[63-i]   = i2s_if.i2s_lrck;
      if (i == chg_at) audio_L = new_l;
    end
    check("bclk_rise_seen", {63'd0, all_ok}, 64'd1);
  endtask

  logic [63:0] data, lr;
  logic        pre, pb, pl, pm;
  int          fs_wait, t, last_fs, last_bc, nfs, fs_bad, hp_bad, lr_tog, lr_bad, mclk_rise, mclk_bad;
  bit          ok;

  localparam logic [63:0] LR_PATTERN = 64'h0000_0001_FFFF_FFFE;

  initial begin
    rstn    = 1'b0;
    audio_L = 16'h8000;
    audio_R = 16'h8000;

    // Reset state
    repeat (100) @(negedge clk);
    check("reset_outputs",
          {59'd0, i2s_if.i2s_mclk, i2s_if.i2s_bclk, i2s_if.i2s_lrck, i2s_if.i2s_sdata, frame_start},
          64'd0);
    rstn = 1'b1;
    wait_fs(200, ok, fs_wait);
    check("first_fs_seen", {63'd0, ok}, 64'd1);
    check("first_fs_within_30", {63'd0, (fs_wait <= 30)}, 64'd1);

    // Slot data and LRCK alignment
    audio_L = 16'h8000; audio_R = 16'h0000;
    rx_frame(-1, 16'h0, data, lr, pre, fs_wait);
    check("data_8000_0000", data, 64'h0000_0000_8000_0000);
    check("lrck_pattern_a", lr, LR_PATTERN);
    audio_L = 16'hFFFF; audio_R = 16'h1234;
    rx_frame(-1, 16'h0, data, lr, pre, fs_wait);
    check("data_ffff_1234", data, 64'h7FFF_0000_9234_0000);
    check("lrck_pattern_b", lr, LR_PATTERN);

    // Input change mid-frame must wait for the next capture
    audio_L = 16'h0000; audio_R = 16'h0000;
    rx_frame(5, 16'hFFFF, data, lr, pre, fs_wait);
    check("hold_current", data, 64'h8000_0000_8000_0000);
    rx_frame(-1, 16'h0, data, lr, pre, fs_wait);
    check("hold_next", data, 64'h7FFF_0000_8000_0000);

    // Frame and BCLK timing over 32 frames
    wait_fs(1300, ok, fs_wait);
    check("timing_sync", {63'd0, ok}, 64'd1);
    t = 0; last_fs = 0; last_bc = -1; nfs = 0; fs_bad = 0; hp_bad = 0;
    lr_tog = 0; lr_bad = 0; mclk_rise = 0; mclk_bad = 0;
    pb = i2s_if.i2s_bclk; pl = i2s_if.i2s_lrck; pm = i2s_if.i2s_mclk;
    while (nfs < 32 && t < 32 * 1250 + 200) begin
      @(negedge clk);
      t++;
      if (i2s_if.i2s_bclk !== pb) begin
        if (last_bc >= 0 && (t - last_bc) != 9 && (t - last_bc) != 10) hp_bad++;
        last_bc = t;
      end
      if (i2s_if.i2s_lrck !== pl) begin
        lr_tog++;
        if (!(pb === 1'b1 && i2s_if.i2s_bclk === 1'b0)) lr_bad++;
      end
      if (pm === 1'b0 && i2s_if.i2s_mclk === 1'b1) mclk_rise++;
`ifndef I2S_MCLK_EN
      if (i2s_if.i2s_mclk !== 1'b0) mclk_bad++;
`endif
      if (frame_start === 1'b1) begin
        nfs++;
        if ((t - last_fs) < 1249 || (t - last_fs) > 1251) fs_bad++;
`ifdef I2S_MCLK_EN
        if (mclk_rise < 255 || mclk_rise > 257) mclk_bad++;
        mclk_rise = 0;
`endif
        last_fs = t;
      end
      pb = i2s_if.i2s_bclk; pl = i2s_if.i2s_lrck; pm = i2s_if.i2s_mclk;
    end
    check("frames_counted", 64'(nfs), 64'd32);
    check("fs_spacing_bad", 64'(fs_bad), 64'd0);
    check("total_40000_pm1", {63'd0, (t >= 39999 && t <= 40001)}, 64'd1);
    check("bclk_half_bad", 64'(hp_bad), 64'd0);
    check("lrck_toggles", 64'(lr_tog), 64'd64);
    check("lrck_not_on_fall", 64'(lr_bad), 64'd0);
    check("mclk_bad", 64'(mclk_bad), 64'd0);

    // Mid-frame reset at bit 40 of the right slot
    audio_L = 16'hFFFF; audio_R = 16'hFFFF;
    wait_fs(1300, ok, fs_wait);
    check("mid_sync", {63'd0, ok}, 64'd1);
    for (int i = 0; i < 42; i++) wait_rise(ok);
    check("pre_reset_sdata", {63'd0, i2s_if.i2s_sdata}, 64'd1);
    rstn = 1'b0;
    #1;
    check("mid_reset_outputs",
          {59'd0, i2s_if.i2s_mclk, i2s_if.i2s_bclk, i2s_if.i2s_lrck, i2s_if.i2s_sdata, frame_start},
          64'd0);
    repeat (5) @(negedge clk);
    audio_L = 16'hC000; audio_R = 16'h8001;
    rstn = 1'b1;
    rx_frame(-1, 16'h0, data, lr, pre, fs_wait);
    check("post_reset_fs_within_30", {63'd0, (fs_wait <= 30)}, 64'd1);
    check("post_reset_no_leftover", {63'd0, pre}, 64'd0);
    check("post_reset_data", data, 64'h4000_0000_0001_0000);
    check("post_reset_lrck", lr, LR_PATTERN);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
